coordinate_streamer: RTL

- Read-side counterpart of the coordinate collection path: drains stored (x, y) coordinate pairs from the coordinate memory and presents them one pair at a time to a downstream consumer (pathfinding core or display) over a valid/ready handshake.
- Sequences synchronous memory reads, holds each pair until accepted, flags the last pair, and pulses done when the list is exhausted.

---
 rtl/coordinate_streamer_if.sv | 23 ++
 rtl/coordinate_streamer.sv | 63 ++++++
 2 files changed

// File: rtl/coordinate_streamer_if.sv
// coordinate_streamer_if: coordinate memory read port plus the valid/ready pair stream
interface coordinate_streamer_if #(
   parameter int COORD_W = 256,
   parameter int ADDR_W  = 6
);
   logic               memRdEn;
   logic [ADDR_W-1:0]  memAddr;
   logic [COORD_W-1:0] memXData;
   logic [COORD_W-1:0] memYData;
   logic [COORD_W-1:0] outX;
   logic [COORD_W-1:0] outY;
   logic               outValid;
   logic               outReady;
   logic               outLast;
   modport master (
      output memRdEn, memAddr, outX, outY, outValid, outLast,
      input  memXData, memYData, outReady
   );
   modport slave (
      input  memRdEn, memAddr, outX, outY, outValid, outLast,
      output memXData, memYData, outReady
   );
endinterface

// File: rtl/coordinate_streamer.sv
// coordinate_streamer: drains stored (x, y) pairs from the coordinate memory onto a
// valid/ready stream, flagging the last pair and pulsing done once the list is exhausted.
module coordinate_streamer #(
   parameter int COORD_W = 256,
   parameter int ADDR_W  = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W:0]       numCoords,
   coordinate_streamer_if.master bus,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic [2:0] {IDLE, READ, WAIT, PRESENT, FINISH} state_t;
   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
   state_t            state, state_nx;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] index;
   logic              accept;
   assign accept       = (state == PRESENT) && bus.outReady;
   assign bus.memRdEn  = (state == READ);
   assign bus.memAddr  = index;
   assign bus.outValid = (state == PRESENT);
   assign busy         = (state != IDLE);
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (numCoords == '0) ? FINISH : READ;
         READ:    state_nx = WAIT;
         WAIT:    state_nx = PRESENT;
         PRESENT: if (bus.outReady) state_nx = bus.outLast ? FINISH : READ;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // done is registered, so it pulses in the cycle after FINISH
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         count       <= '0;
         index       <= '0;
         bus.outX    <= '0;
         bus.outY    <= '0;
         bus.outLast <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= (state == FINISH);
         if (state == IDLE && start) begin
            count <= (numCoords > CAP) ? CAP : numCoords;
            index <= '0;
         end
         if (state == WAIT) begin
            bus.outX    <= bus.memXData;
            bus.outY    <= bus.memYData;
            bus.outLast <= ({1'b0, index} == count - 1'b1);
         end
         if (accept && !bus.outLast) index <= index + 1'b1;
         if (state == FINISH) bus.outLast <= 1'b0;
      end
endmodule
